// File: rtl/rete_pkg.sv
// Shared types and encodings for the rete controller, its repeat counter
// and the rete datapath.
package rete_pkg;

  // Controller states; IDLE is the only state that accepts commands.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } rete_state_e;

  // cmd_op encodings.
  localparam logic [1:0] OP_LOADA = 2'b00;
  localparam logic [1:0] OP_LOADB = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_SEQ   = 2'b11;

  // ALU operation encodings (aluctl / cmd_sub).
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Registered control outputs, decoded from a single state value.
  typedef struct packed {
    logic wea;
    logic web;
    logic mux1;
    logic mux2;
    logic aluctl;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Moore decode: every output is a pure function of the state being
  // entered (plus the latched ALU op while in ACC).
  function automatic ctrl_out_t decode_outputs(input rete_state_e st,
                                               input logic        sub);
    ctrl_out_t o;
    o      = '0;
    o.busy = (st != ST_IDLE);
    case (st)
      ST_LDA: begin
        o.wea  = 1'b1;
        o.mux1 = 1'b0;
      end
      ST_LDB: begin
        o.web  = 1'b1;
        o.mux2 = 1'b0;
      end
      ST_ACC: begin
        o.web    = 1'b1;
        o.mux2   = 1'b1;
        o.aluctl = sub;
      end
      ST_DONE: begin
        o.done = 1'b1;
      end
      default: begin
        o.busy = 1'b0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rete.sv
// Rete datapath: two N-bit registers A and B fed from x/y or the ALU.
// The ALU computes A + B for add and B - A for subtract, so repeated
// subtract on B counts B down by A.
module rete
  import rete_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         wea,
  input  logic         web,
  input  logic         mux1,
  input  logic         mux2,
  input  logic         aluctl,
  output logic [N-1:0] a,
  output logic [N-1:0] b
);

  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] alu;

  // ALU and register source selection.
  always_comb begin
    alu = (aluctl == ALU_SUB) ? (b_q - a_q) : (a_q + b_q);
    a_d = a_q;
    b_d = b_q;
    if (wea) a_d = mux1 ? alu : x;
    if (web) b_d = mux2 ? alu : y;
  end

  // A and B registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a = a_q;
  assign b = b_q;

endmodule

// File: rtl/rete_cnt.sv
// Down-counter holding the remaining ACC repetitions. Loaded on entry to
// ACC, decremented once per ACC cycle, and flags zero on the last cycle.
module rete_cnt
  import rete_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load takes priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rete_ctrl.sv
// Control FSM for the rete datapath: accepts one command at a time and
// sequences register A/B loads and ALU accumulation on B.
//
// Handshake: cmd_ready is high exactly when the FSM is in IDLE and does not
// depend on cmd_valid. A command transfers on a rising edge where
// cmd_valid && cmd_ready; its op/sub/rep are latched on that edge and the
// cmd_* inputs are ignored until the controller returns to IDLE.
module rete_ctrl
  import rete_pkg::*;
#(
  parameter int REP_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_sub,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             wea,
  output logic             web,
  output logic             mux1,
  output logic             mux2,
  output logic             aluctl,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  rete_state_e      state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sub_q, sub_d;
  logic [REP_W-1:0] rep_q, rep_d;
  ctrl_out_t        out_q, out_d;

  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic [REP_W-1:0] cnt_load_val;
  logic             cnt_zero;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  rete_cnt #(.W(REP_W)) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next state, command latching, counter control and output decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sub_d        = sub_q;
    rep_d        = rep_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = rep_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          sub_d = cmd_sub;
          rep_d = cmd_rep;
          case (cmd_op)
            OP_LOADA, OP_SEQ: state_d = ST_LDA;
            OP_LOADB:         state_d = ST_LDB;
            default: begin
              // Plain ACC starts counting straight from the live command.
              state_d      = ST_ACC;
              cnt_load     = 1'b1;
              cnt_load_val = cmd_rep;
            end
          endcase
        end
      end
      ST_LDA: begin
        state_d = (op_q == OP_SEQ) ? ST_LDB : ST_DONE;
      end
      ST_LDB: begin
        if (op_q == OP_SEQ) begin
          state_d      = ST_ACC;
          cnt_load     = 1'b1;
          cnt_load_val = rep_q;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ACC: begin
        // Counter holds the cycles still to run after this one.
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_d = decode_outputs(state_d, sub_d);
  end

  // State, latched command fields and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      sub_q   <= 1'b0;
      rep_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
    end
  end

  assign wea       = out_q.wea;
  assign web       = out_q.web;
  assign mux1      = out_q.mux1;
  assign mux2      = out_q.mux2;
  assign aluctl    = out_q.aluctl;
  assign busy      = out_q.busy;
  assign done      = out_q.done;
  assign dbg_state = state_q;

endmodule
